// File: rtl/mem_copy_engine.sv
// Byte-serial block copier that drives the single-port data memory.
// Each byte takes one READ cycle and one WRITE cycle; the bytes moved are XOR-folded into Checksum.
module mem_copy_engine #(
  parameter int unsigned W = 8,
  parameter int unsigned A = 8
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         Start,
  input  logic [A-1:0] SrcAddr,
  input  logic [A-1:0] DstAddr,
  input  logic [A:0]   Len,
  output logic         Busy,
  output logic         Done,
  output logic [W-1:0] Checksum,
  output logic         MemWriteEn,
  output logic [A-1:0] MemAddress,
  output logic [W-1:0] MemDataOut,
  input  logic [W-1:0] MemDataIn
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]   state_q, state_d;
  logic [A-1:0] src_ptr_q, src_ptr_d;
  logic [A-1:0] dst_ptr_q, dst_ptr_d;
  logic [A:0]   remaining_q, remaining_d;
  logic [W-1:0] data_q, data_d;
  logic [W-1:0] checksum_q, checksum_d;

  always_comb begin
    state_d     = state_q;
    src_ptr_d   = src_ptr_q;
    dst_ptr_d   = dst_ptr_q;
    remaining_d = remaining_q;
    data_d      = data_q;
    checksum_d  = checksum_q;
    case (state_q)
      S_IDLE: begin
        if (Start) begin
          src_ptr_d   = SrcAddr;
          dst_ptr_d   = DstAddr;
          remaining_d = Len;
          checksum_d  = '0;
          state_d     = (Len == '0) ? S_DONE : S_READ;
        end
      end
      S_READ: begin
        data_d     = MemDataIn;
        checksum_d = checksum_q ^ MemDataIn;
        src_ptr_d  = src_ptr_q + A'(1);
        state_d    = S_WRITE;
      end
      S_WRITE: begin
        dst_ptr_d   = dst_ptr_q + A'(1);
        remaining_d = remaining_q - (A+1)'(1);
        state_d     = (remaining_q == (A+1)'(1)) ? S_DONE : S_READ;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q     <= S_IDLE;
      src_ptr_q   <= '0;
      dst_ptr_q   <= '0;
      remaining_q <= '0;
      data_q      <= '0;
      checksum_q  <= '0;
    end else begin
      state_q     <= state_d;
      src_ptr_q   <= src_ptr_d;
      dst_ptr_q   <= dst_ptr_d;
      remaining_q <= remaining_d;
      data_q      <= data_d;
      checksum_q  <= checksum_d;
    end
  end

  // Bus outputs are zero outside READ/WRITE so the datapath can share the memory while idle.
  always_comb begin
    MemAddress = '0;
    MemDataOut = '0;
    MemWriteEn = 1'b0;
    case (state_q)
      S_READ:  MemAddress = src_ptr_q;
      S_WRITE: begin
        MemAddress = dst_ptr_q;
        MemDataOut = data_q;
        MemWriteEn = 1'b1;
      end
      default: ;
    endcase
  end

  assign Busy     = (state_q == S_READ) || (state_q == S_WRITE);
  assign Done     = (state_q == S_DONE);
  assign Checksum = checksum_q;

endmodule

// File: tb/tb_mem_copy_engine.sv
// Scoreboard bench for mem_copy_engine: a 256x8 memory model, a forward byte-copy reference,
// and a negedge monitor that checks bus activity and retires copies on Done.
module tb_mem_copy_engine;

  logic       Clk = 1'b0;
  logic       Reset, Start;
  logic [7:0] SrcAddr, DstAddr;
  logic [8:0] Len;
  logic       Busy, Done, MemWriteEn;
  logic [7:0] Checksum, MemAddress, MemDataOut, MemDataIn;

  always #5 Clk = ~Clk;

  mem_copy_engine #(.W(8), .A(8)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start),
    .SrcAddr(SrcAddr), .DstAddr(DstAddr), .Len(Len),
    .Busy(Busy), .Done(Done), .Checksum(Checksum),
    .MemWriteEn(MemWriteEn), .MemAddress(MemAddress),
    .MemDataOut(MemDataOut), .MemDataIn(MemDataIn)
  );

  // Memory model; the backdoor port is only used while the engine is idle
  logic [7:0] mem [256];
  logic [7:0] ref_mem [256];
  logic       bd_we;
  logic [7:0] bd_addr, bd_data;

  always @(posedge Clk) begin
    if (MemWriteEn) mem[MemAddress] <= MemDataOut;
    else if (bd_we) mem[bd_addr] <= bd_data;
  end
  assign MemDataIn = mem[MemAddress];

  typedef struct {
    int         src;
    int         dst;
    int         len;
    logic [7:0] csum;
  } txn_t;

  txn_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   done_cnt = 0;
  int   busy_idx = 0;
  logic prev_done = 1'b0;
  txn_t mon_t;
  int   mon_mism;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Reference: forward byte-serial copy over the first nbytes, modulo-256 addressing
  function automatic logic [7:0] model_copy(input int src, input int dst, input int nbytes);
    logic [7:0] c;
    logic [7:0] b;
    c = 8'h00;
    for (int i = 0; i < nbytes; i++) begin
      b = ref_mem[(src + i) % 256];
      c = c ^ b;
      ref_mem[(dst + i) % 256] = b;
    end
    return c;
  endfunction

  always @(negedge Clk) begin
    if (Reset) begin
      busy_idx  = 0;
      prev_done = 1'b0;
    end else begin
      if (Busy) begin
        chk("txn_pending", sb.size(), 1);
        if (sb.size() > 0) begin
          mon_t = sb[0];
          chk("busy_we", MemWriteEn, busy_idx % 2);
          if (busy_idx % 2 == 1)
            chk("write_addr", MemAddress, (mon_t.dst + busy_idx / 2) % 256);
          else begin
            chk("read_addr", MemAddress, (mon_t.src + busy_idx / 2) % 256);
            chk("read_dout_zero", MemDataOut, 0);
          end
        end
        busy_idx++;
      end else begin
        chk("idle_we", MemWriteEn, 0);
        chk("idle_dout", MemDataOut, 0);
        if (!Done) chk("idle_addr", MemAddress, 0);
      end
      if (Done) begin
        chk("done_single_cycle", prev_done, 0);
        chk("txn_pending_at_done", sb.size(), 1);
        if (sb.size() > 0) begin
          mon_t = sb.pop_front();
          chk("busy_cycles", busy_idx, 2 * mon_t.len);
          chk("checksum", Checksum, mon_t.csum);
          mon_mism = 0;
          for (int a = 0; a < 256; a++)
            if (mem[a] != ref_mem[a]) mon_mism++;
          chk("mem_image_mismatches", mon_mism, 0);
        end
        busy_idx = 0;
        done_cnt++;
      end
      prev_done = Done;
    end
  end

  task automatic poke(input int addr, input logic [7:0] data);
    bd_addr = addr[7:0];
    bd_data = data;
    bd_we   = 1'b1;
    @(posedge Clk); #1;
    bd_we   = 1'b0;
    ref_mem[addr] = data;
  endtask

  task automatic wait_done(input int d0, input int budget);
    int n;
    n = 0;
    while (done_cnt == d0 && n < budget) begin
      @(posedge Clk); #1;
      n++;
    end
    chk("done_seen", done_cnt, d0 + 1);
  endtask

  task automatic run_copy(input int src, input int dst, input int len, input bit hold);
    txn_t t;
    int   d0;
    t.src  = src;
    t.dst  = dst;
    t.len  = len;
    t.csum = model_copy(src, dst, len);
    sb.push_back(t);
    SrcAddr = src[7:0];
    DstAddr = dst[7:0];
    Len     = len[8:0];
    Start   = 1'b1;
    d0      = done_cnt;
    @(posedge Clk); #1;
    if (!hold) Start = 1'b0;
    SrcAddr = 8'($urandom);
    DstAddr = 8'($urandom);
    Len     = 9'($urandom);
    wait_done(d0, 2 * len + 10);
    chk("idle_after_done", Busy, 0);
    chk("checksum_hold", Checksum, t.csum);
    if (t.len == 0) chk("len0_checksum", Checksum, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_busy"}, Busy, 0);
    chk({tag, "_done"}, Done, 0);
    chk({tag, "_we"}, MemWriteEn, 0);
    chk({tag, "_addr"}, MemAddress, 0);
    chk({tag, "_dout"}, MemDataOut, 0);
    chk({tag, "_checksum"}, Checksum, 0);
  endtask

  initial begin
    txn_t at;
    int   d0;
    int   s;
    Reset = 1'b1; Start = 1'b0; bd_we = 1'b0; bd_addr = '0; bd_data = '0;
    SrcAddr = '0; DstAddr = '0; Len = '0;
    repeat (2) @(posedge Clk);
    #1 Reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      check_reset_outputs("reset_idle");
      @(posedge Clk); #1;
    end

    for (int a = 0; a < 256; a++) poke(a, 8'($urandom));

    // Basic four-byte copy
    poke(8'h10, 8'h11); poke(8'h11, 8'h22); poke(8'h12, 8'h33); poke(8'h13, 8'h44);
    run_copy(8'h10, 8'h80, 4, 1'b0);
    chk("basic_checksum_literal", Checksum, 8'h44);

    // Wrap-around with forward propagation through overlap
    poke(8'hFE, 8'hAA); poke(8'hFF, 8'hBB); poke(8'h00, 8'hCC);
    run_copy(8'hFE, 8'hFF, 3, 1'b0);
    chk("wrap_checksum_literal", Checksum, 8'hAA);

    run_copy($urandom_range(0, 255), $urandom_range(0, 255), 0, 1'b0);

    // Start held high: one copy, then a fresh acceptance after returning to idle
    run_copy(8'h40, 8'h90, 2, 1'b1);
    run_copy(8'h44, 8'hA0, 2, 1'b0);

    for (int r = 0; r < 20; r++) begin
      s = $urandom_range(0, 255);
      if (r % 4 == 0) run_copy(s, (s + $urandom_range(1, 3)) % 256, $urandom_range(1, 8), 1'b0);
      else if (r % 4 == 1) run_copy(s, s, $urandom_range(1, 8), 1'b0);
      else run_copy(s, $urandom_range(0, 255), $urandom_range(0, 12), 1'b0);
    end

    run_copy($urandom_range(0, 255), $urandom_range(0, 255), 256, 1'b0);

    // Reset during the second WRITE of a four-byte copy: two bytes land, no Done
    at.src  = 8'h20;
    at.dst  = 8'hC0;
    at.len  = 4;
    at.csum = model_copy(at.src, at.dst, 2);
    sb.push_back(at);
    SrcAddr = 8'h20; DstAddr = 8'hC0; Len = 9'd4; Start = 1'b1;
    @(posedge Clk); #1;
    Start = 1'b0;
    repeat (3) @(posedge Clk);
    #1 Reset = 1'b1;
    void'(sb.pop_front());
    d0 = done_cnt;
    @(posedge Clk); #1;
    Reset = 1'b0;
    check_reset_outputs("abort");
    repeat (4) @(posedge Clk);
    #1;
    chk("no_done_after_abort", done_cnt, d0);

    run_copy(8'hC0, 8'h60, 4, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
